// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and the
// request bundle presented to the single-ported memory.
package dmem_arbiter_pkg;

  localparam int dmem_addr_width_lp = 32;
  localparam int dmem_data_width_lp = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

  typedef struct packed {
    logic                          wen;
    logic                          byte_not_word;
    logic [dmem_addr_width_lp-1:0] addr;
    logic [dmem_data_width_lp-1:0] write_data;
  } dmem_req_s;

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index at or above ptr,
// wrapping around to 0.
module dmem_arbiter_rr_picker
  import dmem_arbiter_pkg::*;
#(
  parameter  int num_req_p   = 2,
  localparam int id_width_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0]   valid,
  input  logic [id_width_lp-1:0] ptr,
  output logic [id_width_lp-1:0] winner,
  output logic                   any_valid
);

  int best_dist;

  function automatic int dist_from_ptr(input int idx, input int p);
    return (idx >= p) ? (idx - p) : (idx + num_req_p - p);
  endfunction

  // Scan every index and keep the valid one closest (upward) to ptr.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    best_dist = num_req_p;
    for (int j = 0; j < num_req_p; j++) begin
      if (valid[j]) begin
        any_valid = 1'b1;
        if (dist_from_ptr(j, int'(ptr)) < best_dist) begin
          best_dist = dist_from_ptr(j, int'(ptr));
          winner    = id_width_lp'(j);
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between
// num_req_p requesters, with exactly one transaction outstanding.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ARB_IDLE  | examine requests, latch the round-robin winner
//   ARB_ISSUE | drive winner's live request to memory, await mem yumi
//   ARB_WAIT  | forward memory response, await requester yumi
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter  int num_req_p    = 2,
  parameter  int addr_width_p = 32,
  parameter  int data_width_p = 32,
  localparam int id_width_lp  = $clog2(num_req_p)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [num_req_p-1:0]                     req_valid_i,
  input  logic [num_req_p-1:0]                     req_wen_i,
  input  logic [num_req_p-1:0]                     req_byte_i,
  input  logic [num_req_p-1:0][addr_width_p-1:0]   req_addr_i,
  input  logic [num_req_p-1:0][data_width_p-1:0]   req_data_i,
  output logic [num_req_p-1:0]                     req_yumi_o,
  output logic [num_req_p-1:0]                     resp_valid_o,
  output logic [data_width_p-1:0]                  resp_data_o,
  input  logic [num_req_p-1:0]                     resp_yumi_i,
  output logic                                     mem_valid_o,
  output logic                                     mem_wen_o,
  output logic                                     mem_byte_o,
  output logic [addr_width_p-1:0]                  mem_addr_o,
  output logic [data_width_p-1:0]                  mem_data_o,
  input  logic                                     mem_yumi_i,
  input  logic                                     mem_resp_valid_i,
  input  logic [data_width_p-1:0]                  mem_resp_data_i,
  output logic                                     mem_resp_yumi_o,
  output logic [id_width_lp-1:0]                   grant_id_o,
  output logic                                     busy_o
);

  arb_state_e             state_r,    state_n;
  logic [id_width_lp-1:0] grant_id_r, grant_id_n;
  logic [id_width_lp-1:0] rr_ptr_r,   rr_ptr_n;
  logic [id_width_lp-1:0] winner;
  logic                   any_valid;

  dmem_arbiter_rr_picker #(
    .num_req_p (num_req_p)
  ) u_picker (
    .valid     (req_valid_i),
    .ptr       (rr_ptr_r),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ARB_IDLE;
      grant_id_r <= '0;
      rr_ptr_r   <= '0;
    end else begin
      state_r    <= state_n;
      grant_id_r <= grant_id_n;
      rr_ptr_r   <= rr_ptr_n;
    end
  end

  always_comb begin
    state_n         = state_r;
    grant_id_n      = grant_id_r;
    rr_ptr_n        = rr_ptr_r;
    req_yumi_o      = '0;
    resp_valid_o    = '0;
    mem_valid_o     = 1'b0;
    mem_wen_o       = 1'b0;
    mem_byte_o      = 1'b0;
    mem_addr_o      = '0;
    mem_data_o      = '0;
    mem_resp_yumi_o = 1'b0;

    case (state_r)
      ARB_IDLE: begin
        if (any_valid) begin
          grant_id_n = winner;
          state_n    = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        mem_valid_o = req_valid_i[grant_id_r];
        mem_wen_o   = req_wen_i[grant_id_r];
        mem_byte_o  = req_byte_i[grant_id_r];
        mem_addr_o  = req_addr_i[grant_id_r];
        mem_data_o  = req_data_i[grant_id_r];
        req_yumi_o[grant_id_r] = mem_yumi_i & mem_valid_o;
        // A withdrawn request leaves rr_ptr alone so the same requester
        // keeps its priority next time round.
        if (!req_valid_i[grant_id_r]) begin
          state_n = ARB_IDLE;
        end else if (mem_yumi_i) begin
          state_n = ARB_WAIT;
        end
      end

      ARB_WAIT: begin
        resp_valid_o[grant_id_r] = mem_resp_valid_i;
        mem_resp_yumi_o          = resp_yumi_i[grant_id_r] & mem_resp_valid_i;
        if (mem_resp_yumi_o) begin
          rr_ptr_n = (grant_id_r == id_width_lp'(num_req_p - 1)) ? '0 : grant_id_r + 1'b1;
          state_n  = ARB_IDLE;
        end
      end

      default: state_n = ARB_IDLE;
    endcase
  end

  assign resp_data_o = mem_resp_data_i;
  assign grant_id_o  = grant_id_r;
  assign busy_o      = (state_r != ARB_IDLE);

endmodule
